// File: rtl/jump_motion_if.sv
// Handshake bundle between collision/key decode, the jump sequencer, and sprite draw logic.
interface jump_motion_if;
  logic       frame_tick;
  logic       jump_key;
  logic       solid_below;
  logic       solid_above;
  logic       stomp;
  logic       freeze;
  logic [9:0] Y_Pos;
  logic [7:0] Y_Velocity;
  logic       airborne;
  logic [1:0] state;

  modport master (
    output frame_tick, jump_key, solid_below, solid_above, stomp, freeze,
    input  Y_Pos, Y_Velocity, airborne, state
  );
  modport slave (
    input  frame_tick, jump_key, solid_below, solid_above, stomp, freeze,
    output Y_Pos, Y_Velocity, airborne, state
  );
endinterface

// File: rtl/jump_motion_ctrl.sv
// Per-frame vertical motion sequencer: ground/rise/bump/fall FSM with variable-height jump,
// head bump, stomp rebound and ledge walk-off; integrates signed velocity into Y.
module jump_motion_ctrl #(
  parameter int JUMP_V0      = 10,
  parameter int GRAVITY      = 1,
  parameter int RELEASE_GRAV = 3,
  parameter int HOLD_MAX     = 14,
  parameter int MAX_FALL     = 6,
  parameter int BOUNCE_V0    = 6,
  parameter int FLOOR_Y      = 400,
  parameter int Y_INIT       = 400
) (
  input logic          Clk,
  input logic          Reset,
  jump_motion_if.slave bus
);
  localparam int HW = $clog2(HOLD_MAX + 1);

  localparam logic [7:0]    V0_N    = 8'(-JUMP_V0);
  localparam logic [7:0]    BNC_N   = 8'(-BOUNCE_V0);
  localparam logic [7:0]    GRAV8   = 8'(GRAVITY);
  localparam logic [7:0]    RGRAV8  = 8'(RELEASE_GRAV);
  localparam logic [7:0]    MAX8    = 8'(MAX_FALL);
  localparam logic [8:0]    MAX9    = 9'(MAX_FALL);
  localparam logic [9:0]    FLOOR10 = 10'(FLOOR_Y);
  localparam logic [10:0]   FLOOR11 = 11'(FLOOR_Y);
  localparam logic [9:0]    YINIT10 = 10'(Y_INIT);
  localparam logic [HW-1:0] HOLD_L  = HW'(HOLD_MAX);

  typedef enum logic [1:0] {GROUND = 2'd0, RISE = 2'd1, FALL = 2'd2, BUMP = 2'd3} st_t;

  st_t          st;
  logic         air;
  logic [9:0]   y;
  logic [7:0]   vel;
  logic [HW-1:0] hold_cnt;
  logic         stomp_pend;
  logic         key_prev;

  logic         jump_req, stomp_seen, land;
  logic [10:0]  sum;
  logic [9:0]   y_sum;
  logic [7:0]   g, rise_vel, fall_vel;
  logic [8:0]   nv, fv;

  // Velocity math is done one bit wider so the sign of the result is never lost.
  always_comb begin
    jump_req   = bus.jump_key & ~key_prev;
    stomp_seen = stomp_pend | bus.stomp;
    sum        = {1'b0, y} + {{3{vel[7]}}, vel};
    y_sum      = sum[10] ? 10'd0 : sum[9:0];
    land       = !sum[10] && (sum >= FLOOR11);
    g          = (bus.jump_key && hold_cnt < HOLD_L) ? GRAV8 : RGRAV8;
    nv         = {vel[7], vel} + {1'b0, g};
    fv         = {vel[7], vel} + {1'b0, GRAV8};
    rise_vel   = (!nv[8] && nv > MAX9) ? MAX8 : nv[7:0];
    fall_vel   = (!fv[8] && fv > MAX9) ? MAX8 : fv[7:0];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      st         <= GROUND;
      air        <= 1'b0;
      y          <= YINIT10;
      vel        <= '0;
      hold_cnt   <= '0;
      stomp_pend <= 1'b0;
      key_prev   <= 1'b1;
    end else begin
      if (bus.frame_tick) key_prev <= bus.jump_key;
      if (bus.frame_tick && !bus.freeze) begin
        stomp_pend <= 1'b0;
        case (st)
          GROUND: begin
            if (jump_req) begin
              st <= RISE; air <= 1'b1; vel <= V0_N; hold_cnt <= '0;
            end else if (!bus.solid_below && y < FLOOR10) begin
              st <= FALL; air <= 1'b1; vel <= GRAV8;
            end else begin
              vel <= '0;
            end
          end
          RISE: begin
            if (stomp_seen) begin
              vel <= BNC_N; hold_cnt <= bus.jump_key ? '0 : HOLD_L;
            end else if (bus.solid_above) begin
              st <= BUMP; vel <= '0;
            end else begin
              y <= y_sum;
              if (hold_cnt < HOLD_L) hold_cnt <= hold_cnt + 1'b1;
              vel <= rise_vel;
              if (!nv[8]) st <= FALL;
            end
          end
          BUMP: begin
            st <= FALL; vel <= GRAV8;
          end
          FALL: begin
            if (stomp_seen) begin
              st <= RISE; vel <= BNC_N; hold_cnt <= bus.jump_key ? '0 : HOLD_L;
            end else if (land) begin
              st <= GROUND; air <= 1'b0; y <= FLOOR10; vel <= '0;
            end else if (bus.solid_below && !vel[7]) begin
              // Collision unit owns the snap to the tile top; only motion stops here.
              st <= GROUND; air <= 1'b0; vel <= '0;
            end else begin
              y <= y_sum; vel <= fall_vel;
            end
          end
        endcase
      end else if (bus.stomp) begin
        stomp_pend <= 1'b1;
      end
    end
  end

  assign bus.Y_Pos      = y;
  assign bus.Y_Velocity = vel;
  assign bus.airborne   = air;
  assign bus.state      = st;
endmodule

// File: tb/tb_jump_motion_ctrl.sv
// Directed bench for jump_motion_ctrl: trajectories with hand-computed Y/velocity per frame.
module tb_jump_motion_ctrl;
  logic Clk = 1'b0;
  logic Reset;
  int   n_cmp = 0;
  int   n_err = 0;

  jump_motion_if bif ();
  jump_motion_ctrl dut (.Clk(Clk), .Reset(Reset), .bus(bif));

  always #5 Clk = ~Clk;

  int ry[10] = '{390, 381, 373, 366, 360, 355, 351, 348, 346, 345};
  int rv[10] = '{-9, -8, -7, -6, -5, -4, -3, -2, -1, 0};
  int fy[13] = '{345, 346, 348, 351, 355, 360, 366, 372, 378, 384, 390, 396, 400};
  int fv[13] = '{1, 2, 3, 4, 5, 6, 6, 6, 6, 6, 6, 6, 0};

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int ey, input int ev, input int es);
    chk({tag, ".y"},     int'(bif.Y_Pos), ey);
    chk({tag, ".vel"},   int'($signed(bif.Y_Velocity)), ev);
    chk({tag, ".state"}, int'(bif.state), es);
  endtask

  task automatic tick();
    @(negedge Clk); bif.frame_tick = 1'b1;
    @(negedge Clk); bif.frame_tick = 1'b0;
  endtask

  task automatic pulse_stomp();
    @(negedge Clk); bif.stomp = 1'b1;
    @(negedge Clk); bif.stomp = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bif.frame_tick = 0; bif.jump_key = 1; bif.solid_below = 0;
    bif.solid_above = 0; bif.stomp = 0; bif.freeze = 0;
    Reset = 1;

    // Reset with key held: no jump until release then press
    do_reset();
    chk_all("reset", 400, 0, 0);
    chk("reset.air", int'(bif.airborne), 0);
    tick(); chk("held1.state", int'(bif.state), 0);
    tick(); chk("held2.state", int'(bif.state), 0);
    bif.jump_key = 0; tick(); chk("rel.state", int'(bif.state), 0);
    bif.jump_key = 1; tick(); chk_all("launch", 400, -10, 1);
    chk("launch.air", int'(bif.airborne), 1);

    // Full held jump
    for (int i = 0; i < 10; i++) begin
      tick(); chk_all($sformatf("rise%0d", i), ry[i], rv[i], (i == 9) ? 2 : 1);
    end
    for (int i = 0; i < 13; i++) begin
      tick(); chk_all($sformatf("fall%0d", i), fy[i], fv[i], (i == 12) ? 0 : 2);
    end
    chk("landed.air", int'(bif.airborne), 0);

    // Freeze mid-rise, then reset mid-flight
    bif.jump_key = 0; do_reset(); tick();
    bif.jump_key = 1; tick(); tick(); tick();
    chk_all("pre_freeze", 381, -8, 1);
    bif.freeze = 1; repeat (5) tick();
    chk_all("frozen", 381, -8, 1);
    bif.freeze = 0; tick();
    chk_all("resume", 373, -7, 1);
    @(negedge Clk); Reset = 1; @(negedge Clk); Reset = 0;
    chk_all("abort", 400, 0, 0);

    // Short hop: release before 3rd rise tick
    bif.jump_key = 0; tick();
    bif.jump_key = 1; tick(); tick(); tick();
    chk_all("hop2", 381, -8, 1);
    bif.jump_key = 0;
    tick(); chk_all("hop3", 373, -5, 1);
    tick(); chk_all("hop4", 368, -2, 1);
    tick(); chk_all("hop5", 366, 1, 2);

    // Head bump
    do_reset(); tick();
    bif.jump_key = 1; tick(); tick(); tick();
    bif.solid_above = 1; tick(); chk_all("bump", 381, 0, 3);
    bif.solid_above = 0; tick(); chk_all("bump_fall", 381, 1, 2);
    tick(); chk_all("bump_fall2", 382, 2, 2);

    // Stomp with key released: hold window already spent, so later hold gives no lift
    bif.jump_key = 0; pulse_stomp();
    chk_all("stomp_no_tick", 382, 2, 2);
    tick(); chk_all("stomp", 382, -6, 1);
    bif.jump_key = 1;
    tick(); chk_all("stomp_r1", 376, -3, 1);
    tick(); chk_all("stomp_r2", 373, 0, 2);

    // Land on a platform, then walk off its edge
    bif.solid_below = 1; tick(); chk_all("platform", 373, 0, 0);
    bif.solid_below = 0; tick(); chk_all("ledge", 373, 1, 2);
    tick(); chk_all("ledge2", 374, 2, 2);

    // Stomp with key held: low gravity restored
    pulse_stomp(); tick(); chk_all("stomp_held", 374, -6, 1);
    tick(); chk_all("stomp_held_r1", 368, -5, 1);

    // Stomp arriving while frozen is kept until the next live tick
    bif.freeze = 1; pulse_stomp(); tick();
    chk_all("frz_stomp", 368, -5, 1);
    bif.freeze = 0; tick(); chk_all("pend_stomp", 368, -6, 1);

    // Re-press mid-air is not a jump
    bif.jump_key = 0; tick(); chk_all("air_rel", 362, -3, 1);
    bif.jump_key = 1; tick(); chk_all("air_press", 359, -2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
